tpu_skew_feeder: RTL and testbench

Operand streamer between the A/B matrix buffers and the N×N systolic array. On a start pulse it snapshots both matrices. It then drives the array's west edge with rows of A and its north edge with columns of B, each lane delayed by its index, so that A[i][k] and B[k][j] meet in PE(i,j) on the same cycle. It signals busy for the stream window and pulses done when the last lane has drained.

---
 rtl/tpu_skew_feeder.sv | 112 +++++++++++
 tb/tb_tpu_skew_feeder.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/tpu_skew_feeder.sv
`default_nettype none
// ============================================================================
// tpu_skew_feeder : snapshots A/B and streams them diagonally skewed into an
//                   NxN systolic array (A rows west, B columns north).
// Revision: 1.0
// ============================================================================
module tpu_skew_feeder #(
  parameter int N             = 4,
  parameter int DATA_W        = 8,
  parameter int STREAM_CYCLES = 2*N
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [DATA_W*N*N-1:0]      a_flat,
  input  logic [DATA_W*N*N-1:0]      b_flat,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(STREAM_CYCLES+1)-1:0] t_out,
  output logic [DATA_W*N-1:0]        a_west,
  output logic [N-1:0]               a_valid,
  output logic [DATA_W*N-1:0]        b_north,
  output logic [N-1:0]               b_valid
);

  localparam int TW = $clog2(STREAM_CYCLES+1);
  localparam logic [TW-1:0] T_LAST = TW'(STREAM_CYCLES-1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t                  r_state, w_state_nxt;
  logic [TW-1:0]           r_t, w_t_nxt;
  logic                    r_done, w_done_nxt;
  logic                    w_load;
  logic [DATA_W*N*N-1:0]   r_a, r_b;

  always_comb begin
    w_state_nxt = r_state;
    w_t_nxt     = r_t;
    w_done_nxt  = 1'b0;
    w_load      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && !rst) begin
          w_state_nxt = S_RUN;
          w_t_nxt     = '0;
          w_load      = 1'b1;
        end
      end
      S_RUN: begin
        if (r_t == T_LAST) begin
          w_state_nxt = S_IDLE;
          w_t_nxt     = '0;
          w_done_nxt  = 1'b1;
        end else begin
          w_t_nxt = r_t + 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_t     <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_t     <= w_t_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Snapshot contents are don't-care outside RUN, so no reset here.
  always_ff @(posedge clk) begin
    if (w_load) begin
      r_a <= a_flat;
      r_b <= b_flat;
    end
  end

  // Lane i carries element k only when t == i+k; comparing against constant
  // sums keeps out-of-range offsets from ever wrapping onto a real element.
  always_comb begin
    a_west  = '0;
    a_valid = '0;
    b_north = '0;
    b_valid = '0;
    if (r_state == S_RUN) begin
      for (int i = 0; i < N; i++) begin
        for (int k = 0; k < N; k++) begin
          if (r_t == TW'(i + k)) begin
            a_west[i*DATA_W +: DATA_W]  = r_a[(i*N + k)*DATA_W +: DATA_W];
            a_valid[i]                  = 1'b1;
            b_north[i*DATA_W +: DATA_W] = r_b[(k*N + i)*DATA_W +: DATA_W];
            b_valid[i]                  = 1'b1;
          end
        end
      end
    end
  end

  assign busy  = (r_state == S_RUN);
  assign done  = r_done;
  assign t_out = r_t;

endmodule
`default_nettype wire

// File: tb/tb_tpu_skew_feeder.sv
`default_nettype none
// ============================================================================
// tb_tpu_skew_feeder : vector table, corner sequences and randomized run
//                      against a lane-formula reference model.
// Revision: 1.0
// ============================================================================
module tb_tpu_skew_feeder;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int SC = 2*N;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [127:0]  a_flat, b_flat;
  logic          busy, done;
  logic [3:0]    t_out;
  logic [31:0]   a_west, b_north;
  logic [3:0]    a_valid, b_valid;

  int n_checks = 0;
  int n_errors = 0;

  tpu_skew_feeder #(.N(N), .DATA_W(DW), .STREAM_CYCLES(SC)) dut (
    .clk(clk), .rst(rst), .start(start),
    .a_flat(a_flat), .b_flat(b_flat),
    .busy(busy), .done(done), .t_out(t_out),
    .a_west(a_west), .a_valid(a_valid),
    .b_north(b_north), .b_valid(b_valid)
  );

  always #5 clk = ~clk;

  // Reference model: matrices as 2D arrays, lane value by A[i][t-i] rule.
  logic [7:0] ma [N][N];
  logic [7:0] mb [N][N];
  bit         m_busy = 1'b0;
  bit         m_done = 1'b0;
  int         m_t    = 0;

  typedef struct {
    bit          start;
    bit          a_ff;
    bit          e_busy;
    bit          e_done;
    int          e_t;
    logic [31:0] e_aw;
    logic [3:0]  e_av;
    logic [31:0] e_bn;
    logic [3:0]  e_bv;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (time %0t)", nm, act, exp, $time);
    end
  endtask

  task automatic set_pattern();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        a_flat[(r*N+c)*DW +: DW] = 8'(4*r + c + 1);
        b_flat[(r*N+c)*DW +: DW] = 8'(4*r + c + 'h21);
      end
  endtask

  task automatic model_edge();
    if (rst) begin
      m_busy = 1'b0; m_done = 1'b0; m_t = 0;
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        if (m_t == SC-1) begin
          m_busy = 1'b0; m_t = 0; m_done = 1'b1;
        end else begin
          m_t++;
        end
      end else if (start) begin
        m_busy = 1'b1; m_t = 0;
        for (int r = 0; r < N; r++)
          for (int c = 0; c < N; c++) begin
            ma[r][c] = a_flat[(r*N+c)*DW +: DW];
            mb[r][c] = b_flat[(r*N+c)*DW +: DW];
          end
      end
    end
  endtask

  task automatic check_model();
    logic [31:0] eaw, ebn;
    logic [3:0]  eav, ebv;
    int k;
    eaw = '0; ebn = '0; eav = '0; ebv = '0;
    for (int i = 0; i < N; i++) begin
      k = m_t - i;
      if (m_busy && k >= 0 && k < N) begin
        eaw[i*DW +: DW] = ma[i][k];
        ebn[i*DW +: DW] = mb[k][i];
        eav[i] = 1'b1;
        ebv[i] = 1'b1;
      end
    end
    chk("mdl_busy",    busy,    m_busy);
    chk("mdl_done",    done,    m_done);
    chk("mdl_t",       t_out,   m_t);
    chk("mdl_a_west",  a_west,  eaw);
    chk("mdl_a_valid", a_valid, eav);
    chk("mdl_b_north", b_north, ebn);
    chk("mdl_b_valid", b_valid, ebv);
  endtask

  task automatic step(input bit r, input bit s);
    @(negedge clk);
    rst   = r;
    start = s;
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  initial begin
    int cnt;
    rst = 1'b1; start = 1'b0;
    set_pattern();

    tbl[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 0, 32'h00000001, 4'b0001, 32'h00000021, 4'b0001};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 1, 32'h00000502, 4'b0011, 32'h00002225, 4'b0011};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 2, 32'h00090603, 4'b0111, 32'h00232629, 4'b0111};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 3, 32'h0D0A0704, 4'b1111, 32'h24272A2D, 4'b1111};
    tbl[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 4, 32'h0E0B0800, 4'b1110, 32'h282B2E00, 4'b1110};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 5, 32'h0F0C0000, 4'b1100, 32'h2C2F0000, 4'b1100};
    tbl[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 6, 32'h10000000, 4'b1000, 32'h30000000, 4'b1000};
    tbl[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 7, 32'h00000000, 4'b0000, 32'h00000000, 4'b0000};
    tbl[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 0, 32'h00000000, 4'b0000, 32'h00000000, 4'b0000};
    tbl[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 0, 32'h00000000, 4'b0000, 32'h00000000, 4'b0000};

    // Reset held with start high: nothing may start.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
    chk("rst_start_busy", busy, 1'b0);
    step(1'b0, 1'b0);

    // Single window, mid-run overwrite of A, ignored second start.
    for (int v = 0; v < 10; v++) begin
      if (tbl[v].a_ff) a_flat = '1;
      step(1'b0, tbl[v].start);
      chk($sformatf("tbl%0d_busy", v),    busy,    tbl[v].e_busy);
      chk($sformatf("tbl%0d_done", v),    done,    tbl[v].e_done);
      chk($sformatf("tbl%0d_t", v),       t_out,   tbl[v].e_t);
      chk($sformatf("tbl%0d_a_west", v),  a_west,  tbl[v].e_aw);
      chk($sformatf("tbl%0d_a_valid", v), a_valid, tbl[v].e_av);
      chk($sformatf("tbl%0d_b_north", v), b_north, tbl[v].e_bn);
      chk($sformatf("tbl%0d_b_valid", v), b_valid, tbl[v].e_bv);
    end
    set_pattern();

    // Back-to-back: start on the done cycle with new operands.
    cnt = 0;
    step(1'b0, 1'b1);
    cnt += done;
    for (int i = 0; i < 8; i++) begin step(1'b0, 1'b0); cnt += done; end
    chk("b2b_done_first", done, 1'b1);
    a_flat = {$urandom, $urandom, $urandom, $urandom};
    b_flat = {$urandom, $urandom, $urandom, $urandom};
    step(1'b0, 1'b1);
    chk("b2b_restart_busy", busy, 1'b1);
    chk("b2b_restart_t", t_out, 4'd0);
    for (int i = 0; i < 10; i++) begin step(1'b0, 1'b0); cnt += done; end
    chk("b2b_done_count", cnt, 2);
    set_pattern();

    // Reset mid-run: no done pulse, then a normal window.
    step(1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0);
    chk("midrst_t_before", t_out, 4'd5);
    step(1'b1, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_valid", {a_valid, b_valid}, 8'h00);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin step(1'b0, 1'b0); cnt += done; end
    chk("midrst_no_done", cnt, 0);
    step(1'b0, 1'b1);
    cnt = busy;
    for (int i = 0; i < 10; i++) begin step(1'b0, 1'b0); cnt += busy; end
    chk("midrst_busy_len", cnt, 8);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        a_flat = {$urandom, $urandom, $urandom, $urandom};
        b_flat = {$urandom, $urandom, $urandom, $urandom};
      end
      step($urandom_range(0, 49) == 0, $urandom_range(0, 3) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
